updown_counter_mod: RTL and testbench

Parametrised N-bit synchronous up/down counter with programmable terminal value, wrap or saturate mode, parallel load, cascade output, terminal-count pulse and sticky overflow flag. Generalises the team's fixed 8-bit load/enable up/down counter. Intended as the standard counting primitive for timers, address generators and event counters. Instances chain through `cout` → `en` for wider counts.

---
 rtl/counter_pkg.sv | 19 +
 rtl/updown_counter_mod_next.sv | 47 ++++
 rtl/updown_counter_mod.sv | 73 +++++++
 tb/tb_updown_counter_mod.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : shared direction constants and mode encoding for counters
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_t;

endpackage

`default_nettype wire

// File: rtl/updown_counter_mod_next.sv
// ============================================================================
// updown_next : combinational next-count and terminal detection
// Rev 1.0
// ============================================================================
`default_nettype none

module updown_next
  import counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] count,
  input  logic         dir,
  input  logic         mode,
  input  logic [N-1:0] max_val,
  output logic [N-1:0] next_count,
  output logic         at_term
);

  localparam logic [N-1:0] c_ONE = N'(1);

  cnt_mode_t w_mode;

  assign w_mode = cnt_mode_t'(mode);

  always_comb begin
    at_term    = (dir == DIR_UP) ? (count >= max_val) : (count == '0);
    next_count = count;
    if (at_term) begin
      if (w_mode == MODE_SAT) begin
        next_count = (dir == DIR_UP) ? max_val : '0;
      end else begin
        next_count = (dir == DIR_UP) ? '0 : max_val;
      end
    end else if (dir == DIR_UP) begin
      next_count = count + c_ONE;
    end else if (count > max_val) begin
      // A lowered terminal pulls an out-of-range count straight back into range
      next_count = max_val;
    end else begin
      next_count = count - c_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/updown_counter_mod.sv
// ============================================================================
// updown_counter_mod : N-bit up/down counter with load, wrap/saturate, tc, ovf
// Rev 1.0
// ============================================================================
`default_nettype none

module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int           N         = 8,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max_val,
  input  logic         mode,
  output logic [N-1:0] count,
  output logic         cout,
  output logic         tc,
  output logic         ovf
);

  logic [N-1:0] r_count;
  logic         r_tc;
  logic         r_ovf;
  logic [N-1:0] w_next;
  logic         w_at_term;
  logic [N-1:0] w_load_clamped;

  updown_next #(
    .N (N)
  ) u_next (
    .count      (r_count),
    .dir        (dir),
    .mode       (mode),
    .max_val    (max_val),
    .next_count (w_next),
    .at_term    (w_at_term)
  );

  assign w_load_clamped = (load_val > max_val) ? max_val : load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RESET_VAL;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (en) begin
      r_count <= w_next;
      r_tc    <= w_at_term;
      r_ovf   <= r_ovf | w_at_term;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  // Unregistered so a chained stage steps on the same edge as this one wraps
  assign cout  = en & ~load & ~rst & w_at_term;
  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
// ============================================================================
// tb_updown_counter_mod : two chained counters against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst, en, dir, load, mode;
  logic [7:0] load_val, max_val, count;
  logic       cout, tc, ovf;
  logic       hi_load;
  logic [7:0] hi_load_val, hi_count;
  logic       hi_cout, hi_tc, hi_ovf;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  bit m_tc  = 0;
  bit m_ovf = 0;
  int h_cnt = 0;
  bit h_tc  = 0;
  bit h_ovf = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.N(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .max_val(max_val), .mode(mode),
    .count(count), .cout(cout), .tc(tc), .ovf(ovf)
  );

  updown_counter_mod #(.N(8), .RESET_VAL(8'h00)) dut_hi (
    .clk(clk), .rst(rst), .en(cout), .dir(dir), .load(hi_load),
    .load_val(hi_load_val), .max_val(8'hFF), .mode(1'b0),
    .count(hi_count), .cout(hi_cout), .tc(hi_tc), .ovf(hi_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit term(input int c, input bit d, input int mv);
    return d ? (c >= mv) : (c == 0);
  endfunction

  function automatic void mstep(input bit r, input bit l, input bit e, input bit d,
                                input bit md, input int lv, input int mv,
                                inout int c, inout bit t, inout bit o);
    if (r) begin
      c = 0; t = 0; o = 0;
    end else if (l) begin
      c = (lv < mv) ? lv : mv; t = 0; o = 0;
    end else if (e) begin
      if (term(c, d, mv)) begin
        if (md) c = d ? mv : 0;
        else    c = d ? 0 : mv;
        t = 1; o = 1;
      end else begin
        t = 0;
        if (d)           c = c + 1;
        else if (c > mv) c = mv;
        else             c = c - 1;
      end
    end else begin
      t = 0;
    end
  endfunction

  // Per-cycle compare of both stages, then advance the model across the edge
  task automatic cyc();
    bit lo_c, hi_c;
    @(negedge clk);
    lo_c = en && !load && !rst && term(m_cnt, dir, max_val);
    hi_c = lo_c && !hi_load && !rst && term(h_cnt, dir, 255);
    chk("count",    count,    m_cnt);
    chk("tc",       tc,       m_tc);
    chk("ovf",      ovf,      m_ovf);
    chk("cout",     cout,     lo_c);
    chk("hi_count", hi_count, h_cnt);
    chk("hi_tc",    hi_tc,    h_tc);
    chk("hi_ovf",   hi_ovf,   h_ovf);
    chk("hi_cout",  hi_cout,  hi_c);
    mstep(rst, load, en, dir, mode, load_val, max_val, m_cnt, m_tc, m_ovf);
    mstep(rst, hi_load, lo_c, dir, 1'b0, hi_load_val, 255, h_cnt, h_tc, h_ovf);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt [4];
    bit exp_tc  [4];
    int r;
    exp_cnt = '{1, 0, 0, 0};
    exp_tc  = '{0, 0, 1, 1};

    // Reset beats load and enable
    rst = 1; load = 1; en = 1; load_val = 8'h55; max_val = 8'hFF;
    dir = 1; mode = 0; hi_load = 0; hi_load_val = 0;
    @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_tc",    tc,    0);
    chk("rst_ovf",   ovf,   0);
    chk("rst_cout",  cout,  0);

    // Decimal up-count with wrap
    rst = 0; load = 1; load_val = 0; max_val = 9; mode = 0; dir = 1; en = 0;
    cyc();
    load = 0; en = 1;
    for (int i = 1; i <= 10; i++) begin
      #1 chk("wrap_cout", cout, (i == 10));
      cyc();
      chk("wrap_count", count, i % 10);
      chk("wrap_tc",    tc,    (i == 10));
      chk("wrap_ovf",   ovf,   (i == 10));
    end
    en = 0;
    cyc();
    chk("wrap_ovf_sticky", ovf, 1);
    chk("wrap_tc_pulse",   tc,  0);

    // Down-count saturating at zero
    max_val = 200; mode = 1; load = 1; load_val = 2;
    cyc();
    load = 0; dir = 0; en = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sat_count", count, exp_cnt[i]);
      chk("sat_tc",    tc,    exp_tc[i]);
    end
    chk("sat_ovf", ovf, 1);

    // Load above terminal clamps and clears flags
    max_val = 100; load_val = 250; load = 1; en = 1;
    cyc();
    chk("clamp_count", count, 100);
    chk("clamp_ovf",   ovf,   0);
    chk("clamp_tc",    tc,    0);

    // Terminal lowered beneath the current count
    max_val = 255; load_val = 50; load = 1; en = 0;
    cyc();
    load = 0; max_val = 20; mode = 0; dir = 1; en = 1;
    cyc();
    chk("lower_up_count", count, 0);
    chk("lower_up_tc",    tc,    1);
    max_val = 255; load = 1; en = 0;
    cyc();
    load = 0; max_val = 20; dir = 0; en = 1;
    cyc();
    chk("lower_dn_count", count, 20);
    chk("lower_dn_tc",    tc,    0);

    // Carry ripples into the upper stage on the wrapping edge
    en = 0; max_val = 255; mode = 0; dir = 1;
    load = 1; load_val = 8'hFF; hi_load = 1; hi_load_val = 8'h00;
    cyc();
    load = 0; hi_load = 0; en = 1;
    #1 chk("casc_cout", cout, 1);
    cyc();
    chk("casc_value", {hi_count, count}, 16'h0100);
    en = 0;

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      load_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) dir  = ~dir;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 3);
        if (r == 0)      max_val = 0;
        else if (r == 1) max_val = 8'($urandom_range(1, 15));
        else             max_val = 8'($urandom_range(0, 255));
      end
      hi_load     = ($urandom_range(0, 31) == 0);
      hi_load_val = 8'($urandom_range(0, 255));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
